cpu_axi_bridge: RTL and testbench

Converts the core's split inst/data request interfaces (req/addr_ok/data_ok handshake) into one AXI-style master port: AR/R/AW/W/B channels. Sits directly below mycpu_top, which it replaces the raw inst/data SRAM ports of; one outstanding transaction total, data side has priority over inst side.

---
 rtl/cpu_axi_bridge.sv | 127 ++++++++++++
 tb/tb_cpu_axi_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's split inst/data SRAM-like request ports onto a single AXI-style master.
// Only one transaction is in flight at a time, and data requests take priority over inst requests.
module cpu_axi_bridge (
  input  logic        clk,
  input  logic        reset,
  // Instruction side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // Data side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read channels
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write channels
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB} state_e;

  state_e      state;
  logic [31:0] addr;
  logic        src_data;
  logic        aw_fin;
  logic        w_fin;

  assign data_addr_ok = ~reset & (state == StIdle) & data_req;
  assign inst_addr_ok = ~reset & (state == StIdle) & inst_req & ~data_req;

  // Gated by reset so an aborted request can never complete.
  assign inst_data_ok = ~reset & (state == StR) & ~src_data & rvalid;
  assign data_data_ok = ~reset & (((state == StR) & src_data & rvalid) |
                                  ((state == StB) & bvalid));

  assign inst_rdata = rdata;
  assign data_rdata = rdata;
  assign araddr     = addr;
  assign awaddr     = addr;

  // A channel is finished once its valid has dropped or its handshake happens now.
  assign aw_fin = ~awvalid | awready;
  assign w_fin  = ~wvalid | wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      addr     <= 32'h0;
      src_data <= 1'b0;
      wdata    <= 32'h0;
      wstrb    <= 4'h0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (data_addr_ok || inst_addr_ok) begin
            addr     <= data_req ? data_addr : inst_addr;
            src_data <= data_req;
            if (data_req && data_wr) begin
              wdata   <= data_wdata;
              wstrb   <= data_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= StAwW;
            end else begin
              arvalid <= 1'b1;
              state   <= StAr;
            end
          end
        end
        StAr: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= StR;
          end
        end
        StR: begin
          if (rvalid) begin
            rready <= 1'b0;
            state  <= StIdle;
          end
        end
        StAwW: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (aw_fin && w_fin) begin
            bready <= 1'b1;
            state  <= StB;
          end
        end
        StB: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: an accept-decode vector table followed by
// hand-timed read, write, priority and reset-abort sequences.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready;
  logic        bvalid, bready;
  logic [3:0]  wstrb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwr;
    logic        exp_iok;
    logic        exp_dok;
    logic        exp_ar;
    logic        exp_aw;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0; arready = 0; rvalid = 0; rdata = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 32'h0};
    vecs[1] = '{1, 0, 0, 1, 0, 1, 0, 32'hA000_0001};
    vecs[2] = '{0, 1, 0, 0, 1, 1, 0, 32'hB000_0002};
    vecs[3] = '{0, 1, 1, 0, 1, 0, 1, 32'hB000_0003};
    vecs[4] = '{1, 1, 0, 0, 1, 1, 0, 32'hB000_0004};
    vecs[5] = '{1, 1, 1, 0, 1, 0, 1, 32'hB000_0005};

    do_reset();
    #1;
    chk("reset_outputs",
        {27'h0, arvalid, rready, awvalid, wvalid, bready},
        32'h0);
    chk("reset_ok", {28'h0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'h0);
    chk("reset_addr", araddr | awaddr | wdata | {28'h0, wstrb}, 32'h0);

    // Accept decode table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      inst_req  = vecs[i].ireq;
      inst_addr = 32'hA000_0000 + i;
      data_req  = vecs[i].dreq;
      data_wr   = vecs[i].dwr;
      data_addr = 32'hB000_0000 + i;
      #1;
      chk($sformatf("vec%0d_iok", i), {31'h0, inst_addr_ok}, {31'h0, vecs[i].exp_iok});
      chk($sformatf("vec%0d_dok", i), {31'h0, data_addr_ok}, {31'h0, vecs[i].exp_dok});
      tick();
      idle_inputs();
      #1;
      chk($sformatf("vec%0d_ar", i), {31'h0, arvalid}, {31'h0, vecs[i].exp_ar});
      chk($sformatf("vec%0d_aw", i), {31'h0, awvalid}, {31'h0, vecs[i].exp_aw});
      chk($sformatf("vec%0d_addr", i), vecs[i].exp_aw ? awaddr : araddr, vecs[i].exp_addr);
    end

    // Inst read, arready two cycles after arvalid, rvalid three cycles after that
    do_reset();
    inst_req = 1; inst_addr = 32'h1c00_0000;
    #1;
    chk("ird_iok", {31'h0, inst_addr_ok}, 32'h1);
    tick();
    inst_req = 0; inst_addr = 0;
    #1;
    chk("ird_ar1", {31'h0, arvalid}, 32'h1);
    chk("ird_addr1", araddr, 32'h1c00_0000);
    tick();
    #1;
    chk("ird_ar2", {31'h0, arvalid}, 32'h1);
    chk("ird_addr2", araddr, 32'h1c00_0000);
    tick();
    arready = 1;
    #1;
    chk("ird_ar3", {31'h0, arvalid}, 32'h1);
    tick();
    arready = 0;
    #1;
    chk("ird_r_state", {30'h0, arvalid, rready}, 32'h1);
    chk("ird_nodok4", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    tick();
    #1;
    chk("ird_nodok5", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    tick();
    rvalid = 1; rdata = 32'h0280_0000;
    #1;
    chk("ird_dok", {30'h0, inst_data_ok, data_data_ok}, 32'h2);
    chk("ird_rdata", inst_rdata, 32'h0280_0000);
    tick();
    rvalid = 0; rdata = 0;
    #1;
    chk("ird_after", {29'h0, inst_data_ok, data_data_ok, rready}, 32'h0);

    // Data read wins over a simultaneous inst request; inst accepted right after
    do_reset();
    inst_req = 1; inst_addr = 32'h1c00_0040;
    data_req = 1; data_wr = 0; data_addr = 32'h0000_8000;
    #1;
    chk("pri_oks", {30'h0, inst_addr_ok, data_addr_ok}, 32'h1);
    tick();
    data_req = 0; arready = 1;
    #1;
    chk("pri_araddr", araddr, 32'h0000_8000);
    chk("pri_iok_ar", {31'h0, inst_addr_ok}, 32'h0);
    tick();
    arready = 0; rvalid = 1; rdata = 32'h1111_2222;
    #1;
    chk("pri_dok", {29'h0, inst_data_ok, data_data_ok, inst_addr_ok}, 32'h2);
    chk("pri_rdata", data_rdata, 32'h1111_2222);
    tick();
    rvalid = 0;
    #1;
    chk("pri_iok_idle", {30'h0, inst_addr_ok, data_data_ok}, 32'h2);

    // Write with awready after 1 cycle, wready after 3; inst_req held high throughout
    do_reset();
    inst_req = 1; inst_addr = 32'h1c00_0080;
    data_req = 1; data_wr = 1; data_addr = 32'h0000_1000;
    data_wdata = 32'hdead_beef; data_wstrb = 4'h3;
    #1;
    chk("wr_oks", {30'h0, inst_addr_ok, data_addr_ok}, 32'h1);
    tick();
    data_req = 0; data_wr = 0; data_wdata = 0; data_wstrb = 0;
    #1;
    chk("wr_c1_vld", {29'h0, awvalid, wvalid, bready}, 32'h6);
    chk("wr_c1_awaddr", awaddr, 32'h0000_1000);
    chk("wr_c1_wdata", wdata, 32'hdead_beef);
    chk("wr_c1_wstrb", {28'h0, wstrb}, 32'h3);
    chk("wr_c1_iok", {31'h0, inst_addr_ok}, 32'h0);
    tick();
    awready = 1;
    #1;
    chk("wr_c2_vld", {29'h0, awvalid, wvalid, bready}, 32'h6);
    tick();
    awready = 0;
    #1;
    chk("wr_c3_vld", {29'h0, awvalid, wvalid, bready}, 32'h2);
    tick();
    wready = 1;
    #1;
    chk("wr_c4_vld", {29'h0, awvalid, wvalid, bready}, 32'h2);
    chk("wr_c4_wdata", wdata, 32'hdead_beef);
    chk("wr_c4_wstrb", {28'h0, wstrb}, 32'h3);
    tick();
    wready = 0;
    #1;
    chk("wr_c5_vld", {29'h0, awvalid, wvalid, bready}, 32'h1);
    chk("wr_c5_ok", {30'h0, data_data_ok, inst_addr_ok}, 32'h0);
    tick();
    bvalid = 1;
    #1;
    chk("wr_c6_ok", {30'h0, data_data_ok, inst_addr_ok}, 32'h2);
    tick();
    bvalid = 0;
    #1;
    chk("wr_c7_ok", {29'h0, data_data_ok, bready, inst_addr_ok}, 32'h1);

    // Both write handshakes in the entry cycle go straight to B
    do_reset();
    data_req = 1; data_wr = 1; data_addr = 32'h0000_2000;
    data_wdata = 32'h1234_5678; data_wstrb = 4'hf;
    tick();
    data_req = 0; awready = 1; wready = 1;
    #1;
    chk("wrs_c1_vld", {29'h0, awvalid, wvalid, bready}, 32'h6);
    tick();
    awready = 0; wready = 0;
    #1;
    chk("wrs_c2_vld", {29'h0, awvalid, wvalid, bready}, 32'h1);

    // Reset pulsed while waiting in R aborts the read
    do_reset();
    inst_req = 1; inst_addr = 32'h1c00_00c0;
    tick();
    inst_req = 0; arready = 1;
    tick();
    arready = 0;
    #1;
    chk("rst_in_r", {30'h0, arvalid, rready}, 32'h1);
    reset = 1;
    #1;
    chk("rst_cycle_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    tick();
    reset = 0; rvalid = 1; rdata = 32'hffff_0000;
    #1;
    chk("rst_after_vld", {30'h0, arvalid, rready}, 32'h0);
    chk("rst_after_dok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    rvalid = 0;
    inst_req = 1; inst_addr = 32'h1c00_0100;
    #1;
    chk("rst_new_iok", {31'h0, inst_addr_ok}, 32'h1);
    tick();
    inst_req = 0;
    #1;
    chk("rst_new_araddr", araddr, 32'h1c00_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
